// File: rtl/morse_player.sv
// Morse playback sequencer: buffers encoded characters and plays them as ITU-timed tone marks.
// Optional word-space entries (push_len = 0) are enabled by defining MORSE_PLAYER_WORDSPACE_EN.
module morse_player #(
    parameter int MAX_CHARS = 8,
    parameter int UNIT_BASE = 12500000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             turn_on,
    input  logic [2:0]                       speed,
    input  logic                             push_valid,
    input  logic [2:0]                       push_len,
    input  logic [4:0]                       push_code,
    output logic                             push_ready,
    input  logic                             backspace,
    input  logic                             clear,
    input  logic                             start,
    output logic                             tone,
    output logic                             busy,
    output logic [$clog2(MAX_CHARS+1)-1:0]   count,
    output logic [$clog2(MAX_CHARS)-1:0]     char_idx,
    output logic                             done
);

    localparam int CW = $clog2(MAX_CHARS + 1);
    localparam int IW = $clog2(MAX_CHARS);
    localparam logic [31:0] UNIT_L = 32'(UNIT_BASE);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MARK = 3'd1,
        S_SGAP = 3'd2,
        S_CGAP = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    logic [2:0]    r_len  [MAX_CHARS];
    logic [4:0]    r_code [MAX_CHARS];

    state_t        r_state, w_state_nxt, w_ent_state;
    logic [31:0]   r_cnt, w_cnt_nxt, w_ent_cnt;
    logic [31:0]   r_unit, w_unit_nxt, w_spd_raw, w_spd_unit, w_ent_unit;
    logic [IW-1:0] r_char_idx, w_idx_nxt, w_ent_sel;
    logic [2:0]    r_sym, w_sym_nxt, w_sym_inc, w_cur_len;
    logic [4:0]    w_cur_code;
    logic [CW-1:0] r_count, w_count_nxt, w_ent_idx;
    logic          r_tone, r_busy, r_done;
    logic          w_wr, w_len_ok, w_ent_space, w_more_chars;

    // Duration of a k-unit phase expressed as a down-counter load value.
    function automatic logic [31:0] f_span(input logic [2:0] units, input logic [31:0] unit_len);
        f_span = (32'(units) * unit_len) - 32'd1;
    endfunction

    assign w_spd_raw  = UNIT_L >> speed;
    assign w_spd_unit = (w_spd_raw == 32'd0) ? 32'd1 : w_spd_raw;

    assign push_ready = turn_on & ~r_busy & (r_count < CW'(MAX_CHARS)) & ~clear & ~backspace;

    // Entering a character happens either at start (index 0) or at the end of a character gap.
    assign w_ent_idx  = (r_state == S_CGAP) ? (CW'(r_char_idx) + {{(CW-1){1'b0}}, 1'b1}) : {CW{1'b0}};
    assign w_ent_sel  = w_ent_idx[IW-1:0];
    assign w_ent_unit = (r_state == S_CGAP) ? r_unit : w_spd_unit;

`ifdef MORSE_PLAYER_WORDSPACE_EN
    assign w_ent_space = (r_len[w_ent_sel] == 3'd0);
    assign w_len_ok    = (push_len <= 3'd5);
`else
    assign w_ent_space = 1'b0;
    assign w_len_ok    = (push_len != 3'd0) && (push_len <= 3'd5);
`endif

    assign w_cur_len    = r_len[r_char_idx];
    assign w_cur_code   = r_code[r_char_idx];
    assign w_sym_inc    = r_sym + 3'd1;
    assign w_more_chars = (CW'(r_char_idx) + {{(CW-1){1'b0}}, 1'b1}) < r_count;

    // Target phase when moving onto a new buffer entry.
    always_comb begin
        w_ent_state = S_FIN;
        w_ent_cnt   = 32'd0;
        if (w_ent_idx >= r_count) begin
            w_ent_state = S_FIN;
            w_ent_cnt   = 32'd0;
        end else if (w_ent_space) begin
            w_ent_state = S_CGAP;
            w_ent_cnt   = f_span(3'd4, w_ent_unit);
        end else begin
            w_ent_state = S_MARK;
            w_ent_cnt   = f_span(r_code[w_ent_sel][0] ? 3'd3 : 3'd1, w_ent_unit);
        end
    end

    // Next-state, command handling and timing counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_unit_nxt  = r_unit;
        w_idx_nxt   = r_char_idx;
        w_sym_nxt   = r_sym;
        w_count_nxt = r_count;
        w_wr        = 1'b0;
        if (!turn_on) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_FIN: begin
                    w_state_nxt = S_IDLE;
                    if (clear) begin
                        w_count_nxt = {CW{1'b0}};
                    end else if (backspace) begin
                        if (r_count != {CW{1'b0}}) begin
                            w_count_nxt = r_count - {{(CW-1){1'b0}}, 1'b1};
                        end else begin
                            w_count_nxt = r_count;
                        end
                    end else if (start) begin
                        w_state_nxt = w_ent_state;
                        w_cnt_nxt   = w_ent_cnt;
                        w_unit_nxt  = w_spd_unit;
                        w_idx_nxt   = {IW{1'b0}};
                        w_sym_nxt   = 3'd0;
                    end else if (push_ready && push_valid && w_len_ok) begin
                        w_wr        = 1'b1;
                        w_count_nxt = r_count + {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        w_count_nxt = r_count;
                    end
                end
                S_MARK: begin
                    if (r_cnt != 32'd0) begin
                        w_cnt_nxt = r_cnt - 32'd1;
                    end else if (w_sym_inc < w_cur_len) begin
                        w_state_nxt = S_SGAP;
                        w_cnt_nxt   = f_span(3'd1, r_unit);
                    end else if (w_more_chars) begin
                        w_state_nxt = S_CGAP;
                        w_cnt_nxt   = f_span(3'd3, r_unit);
                    end else begin
                        w_state_nxt = S_FIN;
                    end
                end
                S_SGAP: begin
                    if (r_cnt != 32'd0) begin
                        w_cnt_nxt = r_cnt - 32'd1;
                    end else begin
                        w_state_nxt = S_MARK;
                        w_sym_nxt   = w_sym_inc;
                        w_cnt_nxt   = f_span(w_cur_code[w_sym_inc] ? 3'd3 : 3'd1, r_unit);
                    end
                end
                S_CGAP: begin
                    if (r_cnt != 32'd0) begin
                        w_cnt_nxt = r_cnt - 32'd1;
                    end else begin
                        w_state_nxt = w_ent_state;
                        w_cnt_nxt   = w_ent_cnt;
                        w_sym_nxt   = 3'd0;
                        if (w_ent_state != S_FIN) begin
                            w_idx_nxt = w_ent_sel;
                        end else begin
                            w_idx_nxt = r_char_idx;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State, counters and registered outputs decoded from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 32'd0;
            r_unit     <= 32'd1;
            r_char_idx <= {IW{1'b0}};
            r_sym      <= 3'd0;
            r_count    <= {CW{1'b0}};
            r_tone     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_unit     <= w_unit_nxt;
            r_char_idx <= w_idx_nxt;
            r_sym      <= w_sym_nxt;
            r_count    <= w_count_nxt;
            r_tone     <= (w_state_nxt == S_MARK);
            r_busy     <= (w_state_nxt == S_MARK) || (w_state_nxt == S_SGAP) || (w_state_nxt == S_CGAP);
            r_done     <= (w_state_nxt == S_FIN);
        end
    end

    // Character storage has no reset; entries above count are never read.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_len[r_count[IW-1:0]]  <= push_len;
            r_code[r_count[IW-1:0]] <= push_code;
        end
    end

    assign tone     = r_tone;
    assign busy     = r_busy;
    assign done     = r_done;
    assign count    = r_count;
    assign char_idx = r_char_idx;

endmodule

// File: doc/morse_player.md
Name: morse_player

Overview:
- Playback sequencer for the Morse encoder datapath.
- Buffers encoded characters (length + dot/dash pattern) pushed by the encoder's button logic.
- On a start command, drives a single tone/LED line with ITU timing, scaled by the 3-bit speed switches.
- Owns buffer editing: push, backspace and clear. Active only while the encoder mode enable is high.

Parameters:
- MAX_CHARS, 8: buffer depth in characters (power of 2 not required).
- UNIT_BASE, 12500000: clock cycles per Morse unit at speed 0 (125 ms at 100 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- turn_on  in  1  encoder mode enable; low aborts playback and blocks all commands.
- speed  in  3  unit length select; unit = UNIT_BASE >> speed.
- push_valid  in  1  push one character.
- push_len  in  3  symbol count, 1..5.
- push_code  in  5  symbol pattern; bit0 plays first; 1 = dash, 0 = dot.
- push_ready  out  1  high when a push is accepted this cycle.
- backspace  in  1  one-cycle pulse: remove the newest character.
- clear  in  1  one-cycle pulse: empty the buffer.
- start  in  1  one-cycle pulse: play the whole buffer, oldest first.
- tone  out  1  1 during a mark (dot or dash).
- busy  out  1  playback in progress.
- count  out  clog2(MAX_CHARS+1)  characters buffered.
- char_idx  out  clog2(MAX_CHARS)  index of the character being played.
- done  out  1  one-cycle pulse when playback completes.

Behaviour:
- Reset (asynchronous): tone, busy, done = 0; count, char_idx = 0; state IDLE; buffer contents don't-care.
- push_ready = turn_on & ~busy & (count < MAX_CHARS) & ~clear & ~backspace.
  - An accepted push writes entry[count]; count increments next cycle.
  - push_len of 0 or >5 is dropped and count is unchanged (see Optional Feature).
- Command priority in IDLE, per cycle: clear > backspace > start > push.
  - clear: count goes to 0.
  - backspace with count = 0: no-op.
  - All commands are ignored while busy or while turn_on = 0.
- Timing per character:
  - Dot mark = 1 unit; dash mark = 3 units.
  - Gap between symbols of one character = 1 unit off.
  - Gap between characters = 3 units off.
  - No trailing gap after the final mark.
- Unit length is latched from speed on the cycle start is accepted; speed changes during playback have no effect. Unit cycle counter is 32 bits wide; a computed unit of 0 is treated as 1.
- FSM states: IDLE, MARK, SGAP, CGAP, FIN.
  - IDLE to MARK when start is accepted and count > 0. char_idx = 0, symbol index = 0, busy = 1, and tone = 1 from the next cycle.
  - start with count = 0: go to FIN, giving a done pulse on the next cycle with tone never asserted.
  - MARK to SGAP when the mark ends and more symbols remain in the character.
  - MARK to CGAP when the character is finished and more characters remain.
  - MARK to FIN after the last mark of the last character.
  - SGAP and CGAP each return to MARK when their gap ends.
  - FIN: done = 1 and busy = 0 for exactly one cycle, then IDLE.
- Each mark or gap lasts exactly k*unit cycles: tone is registered high for exactly 1*unit (dot) or 3*unit (dash) cycles.
- The buffer is retained after playback, so start replays it.
- turn_on falling mid-playback: next cycle tone = 0, busy = 0, no done pulse, state IDLE; count is preserved.
- rst mid-playback: tone drops immediately (asynchronous); buffer is emptied.

Optional Feature:
- MORSE_PLAYER_WORDSPACE_EN defined:
  - push_len = 0 is accepted as a word-space entry.
  - During playback it produces 4 units off, giving 7 units total off after the preceding 3-unit character gap.
  - A space as the first or last entry plays as 4 units off.
  - Consecutive spaces add 4 units each.
- Not defined: push_len = 0 is dropped as invalid, and no space logic is synthesised.

Test Plan:
- UNIT_BASE=8, speed=1 (unit 4). Push 'A' (len 2, code 00010), start at cycle N:
  - tone 1 on N+1..N+4, 0 on N+5..N+8, 1 on N+9..N+20;
  - done on N+21; busy high on N+1..N+20.
- Push 'E' (len 1, code 0) then 'T' (len 1, code 1), start:
  - tone 1 for 4 cycles, 0 for 12 cycles, 1 for 12 cycles, then done;
  - char_idx goes 0 then 1.
- Fill 8 entries:
  - push_ready = 0 and a 9th push leaves count = 8;
  - backspace then gives count = 7;
  - backspace and push in the same cycle give count = 6.
- start with count = 0: done pulse one cycle later, tone stays 0. Repeat start after a playback: the identical waveform replays.
- Mid-dash turn_on = 0: tone and busy are 0 the next cycle, no done, count unchanged. Assert rst mid-mark: tone is 0 within the same cycle and count = 0.
- Changing speed 1 to 0 during playback: remaining marks keep unit 4. With MORSE_PLAYER_WORDSPACE_EN, 'E', space, 'E' gives 28 cycles of tone 0 between the two marks.
